// File: rtl/mem_bus_arbiter_if.sv
// rtl/mem_bus_arbiter_if.sv - icache/dcache/memory bus signals around the memory port arbiter
interface mem_bus_arbiter_if;
   logic [1:0]  proc2Imem_command;
   logic [31:0] proc2Imem_addr;
   logic [1:0]  proc2Dmem_command;
   logic [31:0] proc2Dmem_addr;
   logic [63:0] proc2Dmem_data;
   logic [3:0]  mem2proc_response;
   logic [63:0] mem2proc_data;
   logic [3:0]  mem2proc_tag;
   logic [1:0]  proc2mem_command;
   logic [31:0] proc2mem_addr;
   logic [63:0] proc2mem_data;
   logic [3:0]  Imem2proc_response;
   logic [63:0] Imem2proc_data;
   logic [3:0]  Imem2proc_tag;
   logic [3:0]  Dmem2proc_response;
   logic [63:0] Dmem2proc_data;
   logic [3:0]  Dmem2proc_tag;

   // slave is the arbiter; master is everything around it (both caches and memory)
   modport slave (
      input  proc2Imem_command, proc2Imem_addr, proc2Dmem_command, proc2Dmem_addr,
             proc2Dmem_data, mem2proc_response, mem2proc_data, mem2proc_tag,
      output proc2mem_command, proc2mem_addr, proc2mem_data,
             Imem2proc_response, Imem2proc_data, Imem2proc_tag,
             Dmem2proc_response, Dmem2proc_data, Dmem2proc_tag
   );

   modport master (
      output proc2Imem_command, proc2Imem_addr, proc2Dmem_command, proc2Dmem_addr,
             proc2Dmem_data, mem2proc_response, mem2proc_data, mem2proc_tag,
      input  proc2mem_command, proc2mem_addr, proc2mem_data,
             Imem2proc_response, Imem2proc_data, Imem2proc_tag,
             Dmem2proc_response, Dmem2proc_data, Dmem2proc_tag
   );
endinterface

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - shares one memory port between icache and dcache and steers tagged returns
// Optional macro ARB_STATS_EN adds igrant/dgrant/conflict counters.
module mem_bus_arbiter #(
   parameter int MAX_STARVE = 4,
   parameter int NUM_TAGS   = 16,
   parameter int CNT_W      = 32
) (
   input  logic             clock,
   input  logic             reset,
   mem_bus_arbiter_if.slave bus
`ifdef ARB_STATS_EN
   ,
   output logic [CNT_W-1:0] igrant_count,
   output logic [CNT_W-1:0] dgrant_count,
   output logic [CNT_W-1:0] conflict_count
`endif
);
   localparam logic [1:0] BUS_NONE  = 2'd0;
   localparam logic [1:0] BUS_LOAD  = 2'd1;
   localparam logic [1:0] BUS_STORE = 2'd2;
   localparam logic [3:0] STARVE_LIM = 4'(MAX_STARVE);

   logic [3:0]          starve_cnt;
   logic [NUM_TAGS-1:0] tag_valid;
   logic [NUM_TAGS-1:0] tag_owner;   // 0 = icache, 1 = dcache

   logic i_req;
   logic d_req;
   logic force_i;
   logic grant_i;
   logic grant_d;
   logic accepted;
   logic alloc;
   logic ret_hit;

   assign i_req    = (bus.proc2Imem_command == BUS_LOAD);
   assign d_req    = (bus.proc2Dmem_command == BUS_LOAD) || (bus.proc2Dmem_command == BUS_STORE);
   assign force_i  = (starve_cnt >= STARVE_LIM) && i_req;
   assign grant_i  = i_req && (force_i || !d_req);
   assign grant_d  = d_req && !grant_i;
   assign accepted = (bus.mem2proc_response != 4'd0);

   // Stores are fire-and-forget: only accepted loads own a tag
   assign alloc    = accepted && (grant_i || (grant_d && bus.proc2Dmem_command == BUS_LOAD));
   assign ret_hit  = (bus.mem2proc_tag != 4'd0) && tag_valid[bus.mem2proc_tag];

   assign bus.proc2mem_command = grant_i ? BUS_LOAD :
                                 grant_d ? bus.proc2Dmem_command : BUS_NONE;
   assign bus.proc2mem_addr    = grant_i ? bus.proc2Imem_addr :
                                 grant_d ? bus.proc2Dmem_addr : 32'd0;
   assign bus.proc2mem_data    = (grant_d && bus.proc2Dmem_command == BUS_STORE) ?
                                 bus.proc2Dmem_data : 64'd0;

   assign bus.Imem2proc_response = grant_i ? bus.mem2proc_response : 4'd0;
   assign bus.Dmem2proc_response = grant_d ? bus.mem2proc_response : 4'd0;
   assign bus.Imem2proc_data     = bus.mem2proc_data;
   assign bus.Dmem2proc_data     = bus.mem2proc_data;
   assign bus.Imem2proc_tag      = (ret_hit && !tag_owner[bus.mem2proc_tag]) ? bus.mem2proc_tag : 4'd0;
   assign bus.Dmem2proc_tag      = (ret_hit &&  tag_owner[bus.mem2proc_tag]) ? bus.mem2proc_tag : 4'd0;

   always_ff @(posedge clock) begin
      if (reset) begin
         starve_cnt <= 4'd0;
         tag_valid  <= '0;
         tag_owner  <= '0;
      end else begin
         // A rejected icache grant neither clears nor advances the starvation count
         if (!i_req || (grant_i && accepted)) begin
            starve_cnt <= 4'd0;
         end else if (!grant_i && starve_cnt != 4'hF) begin
            starve_cnt <= starve_cnt + 4'd1;
         end
         // Allocation is written last so a same-cycle free+reuse of a tag keeps it valid
         if (ret_hit) begin
            tag_valid[bus.mem2proc_tag] <= 1'b0;
         end
         if (alloc) begin
            tag_valid[bus.mem2proc_response] <= 1'b1;
            tag_owner[bus.mem2proc_response] <= grant_d;
         end
      end
   end

`ifdef ARB_STATS_EN
   always_ff @(posedge clock) begin
      if (reset) begin
         igrant_count   <= '0;
         dgrant_count   <= '0;
         conflict_count <= '0;
      end else begin
         if (grant_i && accepted) begin
            igrant_count <= igrant_count + CNT_W'(1);
         end
         if (grant_d && accepted) begin
            dgrant_count <= dgrant_count + CNT_W'(1);
         end
         if (i_req && d_req) begin
            conflict_count <= conflict_count + CNT_W'(1);
         end
      end
   end
`endif
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - table, directed and randomized checks of mem_bus_arbiter against a reference model
module tb_mem_bus_arbiter;
   localparam logic [1:0] BUS_NONE  = 2'd0;
   localparam logic [1:0] BUS_LOAD  = 2'd1;
   localparam logic [1:0] BUS_STORE = 2'd2;
   localparam int MAX_STARVE = 4;

   logic clock = 1'b0;
   logic reset;
   always #5 clock = ~clock;

   mem_bus_arbiter_if bus();

`ifdef ARB_STATS_EN
   logic [31:0] igrant_count, dgrant_count, conflict_count;
`endif

   mem_bus_arbiter #(.MAX_STARVE(MAX_STARVE), .NUM_TAGS(16), .CNT_W(32)) dut (
      .clock(clock),
      .reset(reset),
      .bus(bus)
`ifdef ARB_STATS_EN
      ,
      .igrant_count(igrant_count),
      .dgrant_count(dgrant_count),
      .conflict_count(conflict_count)
`endif
   );

   int errors = 0;
   int checks = 0;

   // Reference model: consecutive denied icache cycles, and a map tag -> owner (0 = I, 1 = D)
   int m_starve;
   int m_owner[int];

   typedef struct {
      logic [1:0]  icmd;
      logic [31:0] iaddr;
      logic [1:0]  dcmd;
      logic [31:0] daddr;
      logic [63:0] ddata;
      logic [3:0]  resp;
      logic [3:0]  rtag;
      logic [63:0] rdata;
      logic [1:0]  e_cmd;
      logic [31:0] e_addr;
      logic [63:0] e_data;
      logic [3:0]  e_iresp;
      logic [3:0]  e_dresp;
      logic [3:0]  e_itag;
      logic [3:0]  e_dtag;
   } vec_t;
   vec_t vecs[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic [1:0] icmd, input logic [31:0] iaddr,
                        input logic [1:0] dcmd, input logic [31:0] daddr, input logic [63:0] ddata,
                        input logic [3:0] resp, input logic [3:0] rtag, input logic [63:0] rdata);
      bus.proc2Imem_command = icmd;
      bus.proc2Imem_addr    = iaddr;
      bus.proc2Dmem_command = dcmd;
      bus.proc2Dmem_addr    = daddr;
      bus.proc2Dmem_data    = ddata;
      bus.mem2proc_response = resp;
      bus.mem2proc_tag      = rtag;
      bus.mem2proc_data     = rdata;
      #1;
   endtask

   // 0 = nobody, 1 = icache, 2 = dcache
   function automatic int model_grant();
      bit ireq, dreq;
      ireq = (bus.proc2Imem_command == BUS_LOAD);
      dreq = (bus.proc2Dmem_command == BUS_LOAD) || (bus.proc2Dmem_command == BUS_STORE);
      if (ireq && (m_starve >= MAX_STARVE || !dreq)) return 1;
      if (dreq) return 2;
      return 0;
   endfunction

   task automatic model_check(input string pfx);
      int g;
      int t;
      logic [1:0]  ecmd;
      logic [31:0] eaddr;
      logic [63:0] edata;
      logic [3:0]  eit, edt;
      g = model_grant();
      t = int'(bus.mem2proc_tag);
      ecmd = BUS_NONE; eaddr = 32'd0; edata = 64'd0; eit = 4'd0; edt = 4'd0;
      if (g == 1) begin
         ecmd = BUS_LOAD; eaddr = bus.proc2Imem_addr;
      end else if (g == 2) begin
         ecmd = bus.proc2Dmem_command; eaddr = bus.proc2Dmem_addr;
         if (ecmd == BUS_STORE) edata = bus.proc2Dmem_data;
      end
      if (t != 0 && m_owner.exists(t)) begin
         if (m_owner[t] == 0) eit = bus.mem2proc_tag;
         else                 edt = bus.mem2proc_tag;
      end
      chk({pfx, ".cmd"},   bus.proc2mem_command, ecmd);
      chk({pfx, ".addr"},  bus.proc2mem_addr, eaddr);
      chk({pfx, ".data"},  bus.proc2mem_data, edata);
      chk({pfx, ".iresp"}, bus.Imem2proc_response, (g == 1) ? bus.mem2proc_response : 4'd0);
      chk({pfx, ".dresp"}, bus.Dmem2proc_response, (g == 2) ? bus.mem2proc_response : 4'd0);
      chk({pfx, ".itag"},  bus.Imem2proc_tag, eit);
      chk({pfx, ".dtag"},  bus.Dmem2proc_tag, edt);
      chk({pfx, ".idata"}, bus.Imem2proc_data, bus.mem2proc_data);
      chk({pfx, ".ddata"}, bus.Dmem2proc_data, bus.mem2proc_data);
   endtask

   // Commit the current cycle into the model, then move to the next negedge
   task automatic step();
      int g;
      int t;
      int r;
      g = model_grant();
      t = int'(bus.mem2proc_tag);
      r = int'(bus.mem2proc_response);
      if (reset) begin
         m_owner.delete();
         m_starve = 0;
      end else begin
         if (t != 0 && m_owner.exists(t)) m_owner.delete(t);
         if (r != 0 && (g == 1 || (g == 2 && bus.proc2Dmem_command == BUS_LOAD)))
            m_owner[r] = (g == 1) ? 0 : 1;
         if (bus.proc2Imem_command != BUS_LOAD) m_starve = 0;
         else if (g == 1) begin
            if (r != 0) m_starve = 0;
         end else if (m_starve < 15) m_starve++;
      end
      @(posedge clock);
      @(negedge clock);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      logic [3:0] rr;

      reset = 1'b1;
      drive(BUS_NONE, 0, BUS_NONE, 0, 0, 0, 0, 0);
      m_owner.delete();
      m_starve = 0;
      repeat (2) @(posedge clock);
      @(negedge clock);
      reset = 1'b0;
      drive(BUS_NONE, 0, BUS_NONE, 0, 0, 0, 0, 0);
      model_check("reset_idle");
      chk("reset_idle.cmd_const", bus.proc2mem_command, BUS_NONE);
      chk("reset_idle.dtag_const", bus.Dmem2proc_tag, 4'd0);

      // icmd iaddr dcmd daddr ddata resp rtag rdata | cmd addr data iresp dresp itag dtag
      vecs.push_back(vec_t'{BUS_NONE, 32'h0, BUS_LOAD, 32'h100, 64'h0, 4'd3, 4'd0, 64'h0,
                            BUS_LOAD, 32'h100, 64'h0, 4'd0, 4'd3, 4'd0, 4'd0});
      vecs.push_back(vec_t'{BUS_NONE, 32'h0, BUS_NONE, 32'h0, 64'h0, 4'd0, 4'd3, 64'hAB,
                            BUS_NONE, 32'h0, 64'h0, 4'd0, 4'd0, 4'd0, 4'd3});
      vecs.push_back(vec_t'{BUS_LOAD, 32'h40, BUS_NONE, 32'h0, 64'h0, 4'd5, 4'd0, 64'h0,
                            BUS_LOAD, 32'h40, 64'h0, 4'd5, 4'd0, 4'd0, 4'd0});
      vecs.push_back(vec_t'{BUS_NONE, 32'h0, BUS_LOAD, 32'h80, 64'h0, 4'd6, 4'd0, 64'h0,
                            BUS_LOAD, 32'h80, 64'h0, 4'd0, 4'd6, 4'd0, 4'd0});
      vecs.push_back(vec_t'{BUS_NONE, 32'h0, BUS_NONE, 32'h0, 64'h0, 4'd0, 4'd6, 64'h66,
                            BUS_NONE, 32'h0, 64'h0, 4'd0, 4'd0, 4'd0, 4'd6});
      vecs.push_back(vec_t'{BUS_NONE, 32'h0, BUS_NONE, 32'h0, 64'h0, 4'd0, 4'd5, 64'h55,
                            BUS_NONE, 32'h0, 64'h0, 4'd0, 4'd0, 4'd5, 4'd0});
      vecs.push_back(vec_t'{BUS_NONE, 32'h0, BUS_STORE, 32'h200, 64'h1234, 4'd2, 4'd0, 64'h0,
                            BUS_STORE, 32'h200, 64'h1234, 4'd0, 4'd2, 4'd0, 4'd0});
      vecs.push_back(vec_t'{BUS_NONE, 32'h0, BUS_NONE, 32'h0, 64'h0, 4'd0, 4'd2, 64'h22,
                            BUS_NONE, 32'h0, 64'h0, 4'd0, 4'd0, 4'd0, 4'd0});
      vecs.push_back(vec_t'{BUS_LOAD, 32'h300, BUS_NONE, 32'h0, 64'h0, 4'd7, 4'd0, 64'h0,
                            BUS_LOAD, 32'h300, 64'h0, 4'd7, 4'd0, 4'd0, 4'd0});
      vecs.push_back(vec_t'{BUS_NONE, 32'h0, BUS_LOAD, 32'h400, 64'h0, 4'd7, 4'd7, 64'h77,
                            BUS_LOAD, 32'h400, 64'h0, 4'd0, 4'd7, 4'd7, 4'd0});
      vecs.push_back(vec_t'{BUS_NONE, 32'h0, BUS_NONE, 32'h0, 64'h0, 4'd0, 4'd7, 64'h78,
                            BUS_NONE, 32'h0, 64'h0, 4'd0, 4'd0, 4'd0, 4'd7});
      vecs.push_back(vec_t'{BUS_NONE, 32'h0, BUS_NONE, 32'h0, 64'h0, 4'd0, 4'd7, 64'h79,
                            BUS_NONE, 32'h0, 64'h0, 4'd0, 4'd0, 4'd0, 4'd0});
      vecs.push_back(vec_t'{BUS_LOAD, 32'h500, BUS_LOAD, 32'h600, 64'h0, 4'd0, 4'd0, 64'h0,
                            BUS_LOAD, 32'h600, 64'h0, 4'd0, 4'd0, 4'd0, 4'd0});
      vecs.push_back(vec_t'{BUS_STORE, 32'h700, BUS_NONE, 32'h0, 64'h0, 4'd9, 4'd0, 64'h0,
                            BUS_NONE, 32'h0, 64'h0, 4'd0, 4'd0, 4'd0, 4'd0});
      vecs.push_back(vec_t'{BUS_NONE, 32'h0, BUS_STORE, 32'h800, 64'hDEAD, 4'd0, 4'd9, 64'h99,
                            BUS_STORE, 32'h800, 64'hDEAD, 4'd0, 4'd0, 4'd0, 4'd0});

      foreach (vecs[i]) begin
         string p;
         p = $sformatf("vec%0d", i);
         drive(vecs[i].icmd, vecs[i].iaddr, vecs[i].dcmd, vecs[i].daddr, vecs[i].ddata,
               vecs[i].resp, vecs[i].rtag, vecs[i].rdata);
         chk({p, ".cmd"},   bus.proc2mem_command, vecs[i].e_cmd);
         chk({p, ".addr"},  bus.proc2mem_addr, vecs[i].e_addr);
         chk({p, ".data"},  bus.proc2mem_data, vecs[i].e_data);
         chk({p, ".iresp"}, bus.Imem2proc_response, vecs[i].e_iresp);
         chk({p, ".dresp"}, bus.Dmem2proc_response, vecs[i].e_dresp);
         chk({p, ".itag"},  bus.Imem2proc_tag, vecs[i].e_itag);
         chk({p, ".dtag"},  bus.Dmem2proc_tag, vecs[i].e_dtag);
         chk({p, ".idata"}, bus.Imem2proc_data, vecs[i].rdata);
         step();
      end

      // Starvation guard: both load every cycle -> D,D,D,D,I repeating
      for (int k = 0; k < 10; k++) begin
         bit exp_i;
         exp_i = ((k % 5) == 4);
         drive(BUS_LOAD, 32'h1000, BUS_LOAD, 32'h2000, 64'h0, 4'(k + 1), 4'd0, 64'h0);
         chk($sformatf("starve%0d.addr", k), bus.proc2mem_addr, exp_i ? 32'h1000 : 32'h2000);
         chk($sformatf("starve%0d.iresp", k), bus.Imem2proc_response, exp_i ? 4'(k + 1) : 4'd0);
         chk($sformatf("starve%0d.dresp", k), bus.Dmem2proc_response, exp_i ? 4'd0 : 4'(k + 1));
         step();
      end
      drive(BUS_NONE, 0, BUS_NONE, 0, 0, 0, 4'd5, 64'h5);
      chk("owner5.itag", bus.Imem2proc_tag, 4'd5);
      chk("owner5.dtag", bus.Dmem2proc_tag, 4'd0);
      step();
      drive(BUS_NONE, 0, BUS_NONE, 0, 0, 0, 4'd6, 64'h6);
      chk("owner6.dtag", bus.Dmem2proc_tag, 4'd6);
      chk("owner6.itag", bus.Imem2proc_tag, 4'd0);
      step();

      // Build starvation to the limit with rejected D grants, then reset with tags 2,4 outstanding
      for (int k = 0; k < 4; k++) begin
         drive(BUS_LOAD, 32'h1000, BUS_LOAD, 32'h2000, 64'h0, 4'd0, 4'd0, 64'h0);
         chk($sformatf("prereset%0d.addr", k), bus.proc2mem_addr, 32'h2000);
         step();
      end
      reset = 1'b1;
      drive(BUS_NONE, 0, BUS_NONE, 0, 0, 0, 0, 0);
      step();
      reset = 1'b0;
      drive(BUS_NONE, 0, BUS_NONE, 0, 0, 0, 0, 0);
      chk("postreset.cmd",  bus.proc2mem_command, BUS_NONE);
      chk("postreset.addr", bus.proc2mem_addr, 32'h0);
      chk("postreset.data", bus.proc2mem_data, 64'h0);
      step();
      drive(BUS_NONE, 0, BUS_NONE, 0, 0, 0, 4'd2, 64'h2);
      chk("postreset2.itag", bus.Imem2proc_tag, 4'd0);
      chk("postreset2.dtag", bus.Dmem2proc_tag, 4'd0);
      step();
      drive(BUS_NONE, 0, BUS_NONE, 0, 0, 0, 4'd4, 64'h4);
      chk("postreset4.dtag", bus.Dmem2proc_tag, 4'd0);
      step();
      drive(BUS_LOAD, 32'h1000, BUS_LOAD, 32'h2000, 64'h0, 4'd1, 4'd0, 64'h0);
      chk("postreset.starve_clear", bus.proc2mem_addr, 32'h2000);
      step();

      // Randomized traffic against the model
      for (int n = 0; n < 600; n++) begin
         logic [1:0] ic, dc;
         ic = 2'($urandom_range(0, 2));
         dc = 2'($urandom_range(0, 2));
         rr = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
         reset = ($urandom_range(0, 63) == 0);
         drive(ic, $urandom & 32'hFFFF_FFF8, dc, $urandom & 32'hFFFF_FFF8,
               {$urandom, $urandom}, rr, 4'($urandom_range(0, 15)), {$urandom, $urandom});
         model_check($sformatf("rand%0d", n));
         step();
      end
      reset = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
